sobel_axis_ctrl: RTL and testbench



---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_out_fifo.sv | 43 ++++
 rtl/sobel_axis_ctrl.sv | 159 +++++++++++++++
 tb/tb_sobel_axis_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel AXI-Stream wrapper.
package sobel_pkg;

  localparam int PIXELS_PER_BEAT_DEF = 16;
  localparam int IMAGE_DIM_DEF       = 512;

  // Beats in one square frame.
  function automatic int frame_beats(input int image_dim, input int pixels_per_beat);
    return (image_dim * image_dim) / pixels_per_beat;
  endfunction

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    CLR   = 2'd2
  } state_e;

  // Sideband token that travels alongside a beat through the core.
  typedef struct packed {
    logic v;
    logic last;
    logic first;
  } tok_t;

endpackage

// File: rtl/sobel_out_fifo.sv
// Small first-word-fall-through FIFO; head entry is always on data_o.
module sobel_out_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage has no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping; push+pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sobel_axis_ctrl.sv
// AXI-Stream wrapper around the stall-driven Sobel core: gates core
// advance on FIFO space, tracks beat tokens through the core latency,
// flushes and resets the core at every frame end.
module sobel_axis_ctrl
  import sobel_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = PIXELS_PER_BEAT_DEF,
  parameter int IMAGE_DIM       = IMAGE_DIM_DEF,
  parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
  parameter int LATENCY         = 14,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  core_stall,
  output logic                  core_aresetn,
  output logic [DATA_WIDTH-1:0] core_inp_frame,
  input  logic [DATA_WIDTH-1:0] core_out_frame,
  output logic                  err_tlast
);

  localparam int FRAME_BEATS = frame_beats(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int BCW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int FCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(FRAME_BEATS - 1);
  localparam logic [FCW-1:0] LAST_FLUSH = FCW'(LATENCY - 1);

  state_e               state_q, state_d;
  logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [FCW-1:0]       flush_cnt_q, flush_cnt_d;
  logic                 err_q, err_d;
  tok_t [LATENCY-1:0]   tok_q;
  tok_t                 tok_in;

  logic [CW-1:0]        fifo_count;
  logic [DATA_WIDTH+1:0] fifo_dout;
  logic                 space, at_last, accept, adv, frame_end;
  logic                 push, pop;

  // Space uses only the registered count, so s_axis_tready never depends
  // on m_axis_tready. Gating with aresetn keeps everything idle in reset.
  assign space   = aresetn & (fifo_count < CW'(FIFO_DEPTH));
  assign at_last = (beat_cnt_q == LAST_BEAT);

  // Next-state, core handshake and frame bookkeeping.
  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    err_d          = err_q;
    s_axis_tready  = 1'b0;
    accept         = 1'b0;
    adv            = 1'b0;
    frame_end      = 1'b0;
    core_inp_frame = '0;
    core_aresetn   = aresetn;
    case (state_q)
      RUN: begin
        s_axis_tready  = space;
        accept         = s_axis_tvalid & space;
        adv            = accept;
        core_inp_frame = s_axis_tdata;
        frame_end      = accept & (s_axis_tlast | at_last);
        if (accept) begin
          // tlast early or missing: flag it, but still end the frame here.
          if (s_axis_tlast != at_last) err_d = 1'b1;
          if (frame_end) begin
            beat_cnt_d  = '0;
            flush_cnt_d = '0;
            state_d     = FLUSH;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end
      end
      FLUSH: begin
        adv = space;
        if (adv) begin
          if (flush_cnt_q == LAST_FLUSH) begin
            flush_cnt_d = '0;
            state_d     = CLR;
          end else begin
            flush_cnt_d = flush_cnt_q + FCW'(1);
          end
        end
      end
      CLR: begin
        core_aresetn = 1'b0;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign core_stall = ~adv;

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= RUN;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  assign tok_in.v     = accept;
  assign tok_in.last  = frame_end;
  assign tok_in.first = (beat_cnt_q == '0);

  // Token pipe moves in lockstep with the core so tokens stay aligned.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      tok_q <= '0;
    end else if (adv) begin
      tok_q[0] <= tok_in;
      for (int i = 1; i < LATENCY; i++) tok_q[i] <= tok_q[i-1];
    end
  end

  // Capture the core output while it is still held, on the advancing cycle.
  assign push = adv & tok_q[LATENCY-1].v;
  assign pop  = m_axis_tvalid & m_axis_tready;

  sobel_out_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .push_i  (push),
    .data_i  ({core_out_frame, tok_q[LATENCY-1].last, tok_q[LATENCY-1].first}),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .count_o (fifo_count)
  );

  assign m_axis_tvalid = aresetn & (fifo_count != '0);
  assign m_axis_tdata  = fifo_dout[DATA_WIDTH+1:2];
  assign m_axis_tlast  = m_axis_tvalid & fifo_dout[1];
  assign m_axis_tuser  = m_axis_tvalid & fifo_dout[0];
  assign err_tlast     = err_q;

endmodule

// File: tb/tb_sobel_axis_ctrl.sv
// Bench for sobel_axis_ctrl: table of frame scenarios plus hand-written
// backpressure and mid-frame reset sequences, against an echo+1 core model.
module tb_sobel_axis_ctrl;
  import sobel_pkg::*;

  localparam int PPB = 16;
  localparam int DIM = 32;
  localparam int DW  = 8 * PPB;
  localparam int LAT = 4;
  localparam int FD  = 4;
  localparam int FB  = 64;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic          core_stall, core_aresetn;
  logic [DW-1:0] core_inp_frame, core_out_frame;
  logic          err_tlast;

  always #5 clk = ~clk;

  sobel_axis_ctrl #(
    .PIXELS_PER_BEAT (PPB),
    .IMAGE_DIM       (DIM),
    .DATA_WIDTH      (DW),
    .LATENCY         (LAT),
    .FIFO_DEPTH      (FD)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tlast   (s_tlast),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuser   (m_tuser),
    .core_stall     (core_stall),
    .core_aresetn   (core_aresetn),
    .core_inp_frame (core_inp_frame),
    .core_out_frame (core_out_frame),
    .err_tlast      (err_tlast)
  );

  // Core model: delay line that moves only when not stalled, output = data+1.
  logic [DW-1:0] line [LAT];
  always @(posedge clk) begin
    if (!core_aresetn) begin
      for (int i = 0; i < LAT; i++) line[i] <= '0;
    end else if (!core_stall) begin
      line[0] <= core_inp_frame;
      for (int i = 1; i < LAT; i++) line[i] <= line[i-1];
    end
  end
  assign core_out_frame = line[LAT-1] + DW'(1);

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          f;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   in_idx = 0, in_cnt = 0, out_cnt = 0;
  int   flush_adv = 0, flush_nz = 0, crst = 0;

  // Scoreboard: predict each accepted beat, compare each popped beat.
  always @(negedge clk) begin
    if (!aresetn) begin
      exp_q.delete();
      in_idx = 0;
    end else begin
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", m_tdata, mon_e.d);
          check("out_tlast", m_tlast, mon_e.l);
          check("out_tuser", m_tuser, mon_e.f);
        end
        out_cnt++;
      end
      if (s_tvalid && s_tready) begin
        mon_e.d = s_tdata + DW'(1);
        mon_e.f = (in_idx == 0);
        mon_e.l = s_tlast || (in_idx == FB - 1);
        exp_q.push_back(mon_e);
        in_idx = mon_e.l ? 0 : in_idx + 1;
        in_cnt++;
      end
      if (!core_stall && !s_tready) begin
        flush_adv++;
        if (core_inp_frame != '0) flush_nz++;
      end
      if (!core_aresetn) crst++;
    end
  end

  function automatic logic [DW-1:0] mkdata(input int r, input int i);
    return {32'hC0DE_0000 | 32'(r), 32'(i), 64'(i * 7 + r * 1000)};
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    bit ok = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (s_tready) ok = 1;
    end
    if (!ok) check("s_tready_timeout", 0, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // Hold m_tready low for 20 cycles once 20 beats are in; after tready drops
  // the front end must stay closed and the core frozen.
  task automatic bp_hold();
    bit dropped = 0;
    for (int k = 0; k < 2000 && in_cnt < 20; k++) @(negedge clk);
    @(posedge clk); #1;
    m_tready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dropped) begin
        check("bp_tready_low", s_tready, 0);
        check("bp_stall", core_stall, 1);
      end else if (!s_tready) begin
        dropped = 1;
        check("bp_fifo_valid", m_tvalid, 1);
      end
    end
    check("bp_tready_dropped", dropped, 1);
    @(posedge clk); #1;
    m_tready = 1'b1;
  endtask

  typedef struct {
    int n;
    int tl;
    bit bub;
    bit bp;
    int exp_out;
    bit exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic run_row(input int r);
    vec_t v;
    v = tbl[r];
    out_cnt = 0; in_cnt = 0; flush_adv = 0; flush_nz = 0; crst = 0;
    fork
      for (int i = 0; i < v.n; i++) begin
        send_beat(mkdata(r, i), (i == v.tl));
        if (v.exp_err && i == v.n - 1) check("err_tlast_rise", err_tlast, 1);
        if (v.bub && (i % 2 == 1) && i < v.n - 1) begin
          @(negedge clk);
          check("bubble_stall", core_stall, 1);
          @(posedge clk); #1;
        end
      end
      if (v.bp) bp_hold();
    join
    drain();
    check("out_count", out_cnt, v.exp_out);
    check("err_tlast", err_tlast, v.exp_err);
    check("flush_advances", flush_adv, LAT);
    check("flush_zero_input", flush_nz, 0);
    check("core_reset_pulses", crst, 1);
  endtask

  // Reset with 3 entries parked in the FIFO at input beat 30.
  task automatic reset_mid_frame();
    for (int i = 0; i < 27; i++) send_beat(mkdata(9, i), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    m_tready = 1'b0;
    for (int i = 27; i < 30; i++) send_beat(mkdata(9, i), 1'b0);
    @(negedge clk);
    check("rst_fifo_holding", m_tvalid, 1);
    @(posedge clk); #1;
    s_tdata  = mkdata(9, 30);
    s_tvalid = 1'b1;
    aresetn  = 1'b0;
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_core_aresetn", core_aresetn, 0);
    check("rst_core_stall", core_stall, 1);
    repeat (2) @(posedge clk);
    #1;
    aresetn  = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_no_output", m_tvalid, 0);
    check("post_rst_err_clear", err_tlast, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{n: 64, tl: 63, bub: 0, bp: 0, exp_out: 64, exp_err: 0};  // continuous
    tbl[1] = '{n: 64, tl: 63, bub: 1, bp: 0, exp_out: 64, exp_err: 0};  // bubbles
    tbl[2] = '{n: 64, tl: 63, bub: 0, bp: 1, exp_out: 64, exp_err: 0};  // backpressure
    tbl[3] = '{n: 41, tl: 40, bub: 0, bp: 0, exp_out: 41, exp_err: 1};  // early tlast
    tbl[4] = '{n: 64, tl: 63, bub: 0, bp: 0, exp_out: 64, exp_err: 1};  // next frame, err sticky
    tbl[5] = '{n: 64, tl: 63, bub: 0, bp: 0, exp_out: 64, exp_err: 0};  // after mid-frame reset
    tbl[6] = '{n: 64, tl: -1, bub: 0, bp: 0, exp_out: 64, exp_err: 1};  // missing tlast

    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_s_tready", s_tready, 0);
    check("reset_m_tvalid", m_tvalid, 0);
    check("reset_m_tlast", m_tlast, 0);
    check("reset_m_tuser", m_tuser, 0);
    check("reset_err", err_tlast, 0);
    check("reset_core_stall", core_stall, 1);
    check("reset_core_aresetn", core_aresetn, 0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    check("idle_s_tready", s_tready, 1);
    check("idle_core_stall", core_stall, 1);
    check("idle_core_aresetn", core_aresetn, 1);
    @(posedge clk); #1;

    for (int r = 0; r < 5; r++) run_row(r);
    reset_mid_frame();
    for (int r = 5; r < 7; r++) run_row(r);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_cmp);
    $fatal(1);
  end

endmodule
